sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
Single-clock first-in-first-out buffer. It is the queue-order counterpart to the team's stack buffer and keeps the same push/pop gating conventions, so the two are interchangeable at the port level. It stores up to 2**depth words of N bits, with a registered read data output. It also provides occupancy count, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags. It sits between producer and consumer stages running on the same clock.

Parameters:
N, 32, data word width in bits
depth, 3, log2 of storage depth; DEPTH = 2**depth words
AF_MARGIN, 1, almost_full asserts when count >= DEPTH - AF_MARGIN
AE_MARGIN, 1, almost_empty asserts when count <= AE_MARGIN

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous clear of pointers, count and error flags
wr_en  input  1  push request
rd_en  input  1  pop request
din  input  N  push data
dout  output  N  registered pop data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= DEPTH - AF_MARGIN
almost_empty  output  1  count <= AE_MARGIN
count  output  depth+1  current occupancy, range 0..DEPTH
overflow  output  1  sticky: push attempted while full
underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Reset is asynchronous and active-high. Interface: reset reset, asynchronous, active-high; clock clk.
- On reset:
  - wr_ptr, rd_ptr and count go to 0.
  - dout = 0, overflow = 0, underflow = 0.
  - Memory contents are not cleared.
- Flag outputs:
  - full, empty, almost_full and almost_empty are combinational from count.
  - After reset: empty = 1, almost_empty = 1, full = 0, almost_full = 0.
- Acceptance:
  - push_ok = wr_en && !full.
  - pop_ok = rd_en && !empty.
  - Acceptance is evaluated on pre-edge state.
- Push only: mem[wr_ptr] <= din; wr_ptr +1; count +1.
- Pop only: dout <= mem[rd_ptr]; rd_ptr +1; count -1.
  - dout is valid the cycle after the accepted pop edge.
  - dout holds its value in every cycle without an accepted pop.
- Push and pop together (neither full nor empty): both execute and count is unchanged.
  - The popped word is the oldest entry, never din.
- Full with wr_en and rd_en: pop executes, push is rejected, overflow sets. Count becomes DEPTH-1.
- Empty with wr_en and rd_en: push executes, pop is rejected (no bypass), underflow sets. dout holds. Count becomes 1.
- Pointers are depth bits wide and wrap modulo DEPTH naturally. Count is depth+1 bits and never exceeds DEPTH or goes below 0.
- overflow sets on wr_en && full; underflow sets on rd_en && empty. Both stay set until reset or flush.
- flush (synchronous, priority over push/pop in the same cycle):
  - Clears pointers, count, overflow and underflow.
  - dout holds; memory is untouched.
- Reset asserted mid-operation: immediate return to reset state regardless of clock. Pending push/pop in that cycle is discarded.
- Parameter constraints:
  - 0 <= AF_MARGIN < DEPTH.
  - 0 <= AE_MARGIN < DEPTH.

Decomposition:
- Shared package: none required. Derived localparam DEPTH = 2**depth stays local.
- One natural sub-module: sync_fifo_ram. It is a simple dual-port array with one synchronous write port (we, waddr, wdata) and one registered read port (re, raddr, rdata held when re = 0). The rdata register drives dout and resets to 0.
- Pointer, count and flag logic live in the top level.

Test Plan:
All scenarios use N = 32, depth = 3 (DEPTH = 8), AF_MARGIN = 1, AE_MARGIN = 1.
1. Reset: assert reset mid-clock with no edge -> immediately count=0, empty=1, almost_empty=1, full=0, dout=0, overflow=0, underflow=0.
2. Fill and overflow: push 0x10..0x17 -> almost_empty drops at count=2, almost_full rises at count=7, full=1 at count=8. A 9th push of 0x99 -> overflow=1, count stays 8.
3. Drain and underflow: pop 8 times -> dout = 0x10, 0x11, ..., 0x17, each one cycle after its pop; empty=1 after the last. A further pop -> underflow=1, dout holds 0x17.
4. Wrap-around: push 5, pop 5, then push 0xA0..0xA5 and pop 6 -> dout = 0xA0..0xA5 in order across the pointer wrap; count returns to 0.
5. Simultaneous ops:
   - At count=3, push and pop together -> count stays 3 and dout is the oldest entry.
   - At full, push and pop together -> count=7, overflow=1.
   - At empty, push and pop together -> count=1, underflow=1, dout unchanged.
6. Flush and reset mid-stream:
   - At count=5 with overflow set, flush with wr_en=1 -> count=0, overflow=0, dout unchanged, no write.
   - Then push 3, assert reset mid-cycle -> count=0, dout=0.

Source files
------------

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage array for sync_fifo: one synchronous write port and
// one registered read port whose output register holds while re is low.
module sync_fifo_ram #(
    parameter int N     = 32,
    parameter int depth = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [depth-1:0] waddr,
    input  logic [N-1:0]     wdata,
    input  logic             re,
    input  logic [depth-1:0] raddr,
    output logic [N-1:0]     rdata
);
    localparam int DEPTH = 2 ** depth;

    logic [N-1:0] mem [0:DEPTH-1];
    logic [N-1:0] rdata_reg;

    // Array has no reset so it can map onto block RAM; only the output register resets.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count, programmable
// almost-full/almost-empty flags and sticky overflow/underflow flags.
module sync_fifo #(
    parameter int N         = 32,
    parameter int depth     = 3,
    parameter int AF_MARGIN = 1,
    parameter int AE_MARGIN = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    input  logic           wr_en,
    input  logic           rd_en,
    input  logic [N-1:0]   din,
    output logic [N-1:0]   dout,
    output logic           full,
    output logic           empty,
    output logic           almost_full,
    output logic           almost_empty,
    output logic [depth:0] count,
    output logic           overflow,
    output logic           underflow
);
    localparam int DEPTH = 2 ** depth;
    localparam logic [depth:0]   COUNT_FULL = (depth + 1)'(DEPTH);
    localparam logic [depth:0]   AF_LEVEL   = (depth + 1)'(DEPTH - AF_MARGIN);
    localparam logic [depth:0]   AE_LEVEL   = (depth + 1)'(AE_MARGIN);
    localparam logic [depth:0]   COUNT_ONE  = (depth + 1)'(1);
    localparam logic [depth-1:0] PTR_ONE    = depth'(1);

    logic [depth-1:0] wr_ptr_reg, wr_ptr_next;
    logic [depth-1:0] rd_ptr_reg, rd_ptr_next;
    logic [depth:0]   count_reg, count_next;
    logic             overflow_reg, overflow_next;
    logic             underflow_reg, underflow_next;
    logic             push_ok, pop_ok;
    logic             ram_we, ram_re;

    assign full         = (count_reg == COUNT_FULL);
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= AF_LEVEL);
    assign almost_empty = (count_reg <= AE_LEVEL);

    assign push_ok = wr_en && !full;
    assign pop_ok  = rd_en && !empty;

    // Flush wins over both ports, so neither the array nor dout may change that cycle.
    assign ram_we = push_ok && !flush;
    assign ram_re = pop_ok && !flush;

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;
        if (flush) begin
            wr_ptr_next    = '0;
            rd_ptr_next    = '0;
            count_next     = '0;
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            if (push_ok && !pop_ok) begin
                count_next = count_reg + COUNT_ONE;
            end else if (pop_ok && !push_ok) begin
                count_next = count_reg - COUNT_ONE;
            end
            if (wr_en && full) begin
                overflow_next = 1'b1;
            end
            if (rd_en && empty) begin
                underflow_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    sync_fifo_ram #(
        .N     (N),
        .depth (depth)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .waddr (wr_ptr_reg),
        .wdata (din),
        .re    (ram_re),
        .raddr (rd_ptr_reg),
        .rdata (dout)
    );

    assign count     = count_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_sync_fifo;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        full, empty, almost_full, almost_empty;
    logic [3:0]  count;
    logic        overflow, underflow;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model state
    logic [31:0] q[$];
    logic [31:0] m_dout = '0;
    bit          m_ovf = 1'b0;
    bit          m_unf = 1'b0;

    sync_fifo #(.N(32), .depth(3), .AF_MARGIN(1), .AE_MARGIN(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .din          (din),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    // Model: FIFO as a queue, updated from the pre-edge view of its own state.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                q.delete();
                m_dout = '0;
                m_ovf  = 1'b0;
                m_unf  = 1'b0;
            end else if (flush) begin
                q.delete();
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end else begin
                automatic bit was_full  = (q.size() == 8);
                automatic bit was_empty = (q.size() == 0);
                if (wr_en && was_full) m_ovf = 1'b1;
                if (rd_en && was_empty) m_unf = 1'b1;
                if (rd_en && !was_empty) m_dout = q.pop_front();
                if (wr_en && !was_full) q.push_back(din);
            end
        end
    end

    // Compare process: all outputs against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                automatic int sz = q.size();
                check("cyc_count", 32'(count), 32'(sz));
                check("cyc_full", 32'(full), 32'(sz == 8));
                check("cyc_empty", 32'(empty), 32'(sz == 0));
                check("cyc_almost_full", 32'(almost_full), 32'(sz >= 7));
                check("cyc_almost_empty", 32'(almost_empty), 32'(sz <= 1));
                check("cyc_dout", dout, m_dout);
                check("cyc_overflow", 32'(overflow), 32'(m_ovf));
                check("cyc_underflow", 32'(underflow), 32'(m_unf));
            end
        end
    end

    task automatic step(input logic w, input logic r, input logic [31:0] d, input logic f);
        wr_en = w;
        rd_en = r;
        din   = d;
        flush = f;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        flush = 1'b0;
        $display("txn wr=%0d rd=%0d fl=%0d din=%h -> count=%0d dout=%h ovf=%0d unf=%0d",
                 w, r, f, d, count, dout, overflow, underflow);
    endtask

    task automatic mid_cycle_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_almost_empty", 32'(almost_empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_almost_full", 32'(almost_full), 32'd0);
        check("rst_dout", dout, 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        $display("txn mid-cycle reset -> count=%0d dout=%h", count, dout);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;

        // 1: asynchronous reset with data in flight, no edge needed
        step(1, 0, 32'h5, 0);
        step(1, 0, 32'h6, 0);
        step(0, 1, 32'h0, 0);
        check("pre_reset_dout", dout, 32'h5);
        mid_cycle_reset();

        // 2: fill and overflow
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 32'h10 + 32'(i), 0);
            check("fill_count", 32'(count), 32'(i + 1));
            if (i == 0) check("fill_ae_at1", 32'(almost_empty), 32'd1);
            if (i == 1) check("fill_ae_at2", 32'(almost_empty), 32'd0);
            if (i == 5) check("fill_af_at6", 32'(almost_full), 32'd0);
            if (i == 6) check("fill_af_at7", 32'(almost_full), 32'd1);
            if (i == 6) check("fill_full_at7", 32'(full), 32'd0);
        end
        check("fill_full_at8", 32'(full), 32'd1);
        step(1, 0, 32'h99, 0);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd8);

        // 3: drain and underflow
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 32'h0, 0);
            check("drain_dout", dout, 32'h10 + 32'(i));
        end
        check("drain_empty", 32'(empty), 32'd1);
        step(0, 1, 32'h0, 0);
        check("unf_set", 32'(underflow), 32'd1);
        check("unf_dout_hold", dout, 32'h17);

        // 4: wrap-around
        for (int i = 0; i < 5; i++) step(1, 0, 32'h20 + 32'(i), 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 32'h0, 0);
            check("pre_wrap_dout", dout, 32'h20 + 32'(i));
        end
        for (int i = 0; i < 6; i++) step(1, 0, 32'hA0 + 32'(i), 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 32'h0, 0);
            check("wrap_dout", dout, 32'hA0 + 32'(i));
        end
        check("wrap_count", 32'(count), 32'd0);

        // 5: simultaneous push and pop
        step(0, 0, 32'h0, 1);
        check("flush_clr_ovf", 32'(overflow), 32'd0);
        check("flush_clr_unf", 32'(underflow), 32'd0);
        for (int i = 0; i < 3; i++) step(1, 0, 32'h30 + 32'(i), 0);
        step(1, 1, 32'h33, 0);
        check("both_mid_count", 32'(count), 32'd3);
        check("both_mid_dout", dout, 32'h30);
        for (int i = 0; i < 5; i++) step(1, 0, 32'h34 + 32'(i), 0);
        check("both_full_pre", 32'(full), 32'd1);
        step(1, 1, 32'h77, 0);
        check("both_full_count", 32'(count), 32'd7);
        check("both_full_ovf", 32'(overflow), 32'd1);
        check("both_full_dout", dout, 32'h31);
        for (int i = 0; i < 7; i++) step(0, 1, 32'h0, 0);
        check("both_full_last", dout, 32'h38);
        step(1, 1, 32'h55, 0);
        check("both_empty_count", 32'(count), 32'd1);
        check("both_empty_unf", 32'(underflow), 32'd1);
        check("both_empty_dout", dout, 32'h38);
        step(0, 1, 32'h0, 0);
        check("both_empty_pop", dout, 32'h55);

        // 6: flush with a push pending, then reset mid-stream
        for (int i = 0; i < 5; i++) step(1, 0, 32'h60 + 32'(i), 0);
        check("pre_flush_ovf", 32'(overflow), 32'd1);
        step(1, 1, 32'hEE, 1);
        check("flush_count", 32'(count), 32'd0);
        check("flush_ovf", 32'(overflow), 32'd0);
        check("flush_dout", dout, 32'h55);
        step(1, 0, 32'h70, 0);
        step(0, 1, 32'h0, 0);
        check("post_flush_dout", dout, 32'h70);
        for (int i = 0; i < 3; i++) step(1, 0, 32'h80 + 32'(i), 0);
        check("pre_reset2_count", 32'(count), 32'd3);
        mid_cycle_reset();
        step(0, 0, 32'h0, 0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
